// File: rtl/systolic_os_gemm_if.sv
// systolic_os_gemm_if: job control, operand beat and result row handshakes for systolic_os_gemm
interface systolic_os_gemm_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int DIM_1       = 4,
   parameter int DIM_2       = 4,
   parameter int K_WIDTH     = 10,
   parameter int SHIFT_WIDTH = 6
);
   localparam int IW = DIM_1 > 1 ? $clog2(DIM_1) : 1;
   logic                        start;
   logic [K_WIDTH-1:0]          k_len;
   logic [SHIFT_WIDTH-1:0]      q_shift;
   logic                        in_valid;
   logic                        in_ready;
   logic [DATA_WIDTH*DIM_2-1:0] i_1;
   logic [DATA_WIDTH*DIM_1-1:0] i_2;
   logic                        out_valid;
   logic                        out_ready;
   logic [DATA_WIDTH*DIM_2-1:0] out_row;
   logic [IW-1:0]               out_idx;
   logic                        busy;
   logic                        done;
   modport master (
      output start, k_len, q_shift, in_valid, i_1, i_2, out_ready,
      input  in_ready, out_valid, out_row, out_idx, busy, done
   );
   modport slave (
      input  start, k_len, q_shift, in_valid, i_1, i_2, out_ready,
      output in_ready, out_valid, out_row, out_idx, busy, done
   );
endinterface

// File: rtl/systolic_os_gemm.sv
// systolic_os_gemm: output-stationary signed GEMM tile with skewed operands and row-serial quantised drain; define SYSTOLIC_SAT_EN to saturate instead of wrap
module systolic_os_gemm #(
   parameter int DATA_WIDTH  = 16,
   parameter int DIM_1       = 4,
   parameter int DIM_2       = 4,
   parameter int ACC_WIDTH   = 40,
   parameter int K_WIDTH     = 10,
   parameter int SHIFT_WIDTH = 6
) (
   input logic clk,
   input logic rst_n,
   systolic_os_gemm_if.slave bus
);
   localparam int IW = DIM_1 > 1 ? $clog2(DIM_1) : 1;
   localparam int FW = $clog2(DIM_1 + DIM_2) + 1;
   localparam int TW = DATA_WIDTH + 1;
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
   state_t r_state, w_next;
   logic [K_WIDTH-1:0]     r_klen, r_beat;
   logic [SHIFT_WIDTH-1:0] r_shift;
   logic [FW-1:0]          r_fc;
   logic [IW-1:0]          r_idx;
   logic                   r_done;
   logic                   w_start, w_beat, w_drain, w_out_hs, w_last_row;
   logic [TW-1:0]          w_a_col [DIM_1];
   logic [TW-1:0]          w_b_row [DIM_2];
   logic [TW-1:0]          w_ah [DIM_1][DIM_2];
   logic [TW-1:0]          w_bv [DIM_1][DIM_2];
   logic signed [ACC_WIDTH-1:0] w_acc [DIM_1][DIM_2];
   logic [DATA_WIDTH*DIM_2-1:0] w_row;
   assign w_start    = r_state == IDLE && bus.start;
   assign w_beat     = r_state == LOAD && bus.in_valid;
   assign w_drain    = r_state == DRAIN;
   assign w_out_hs   = w_drain && bus.out_ready;
   assign w_last_row = r_idx == IW'(DIM_1 - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = bus.k_len == '0 ? DRAIN : LOAD;
         LOAD:    if (w_beat && r_beat == r_klen - K_WIDTH'(1)) w_next = FLUSH;
         FLUSH:   if (r_fc == FW'(DIM_1 + DIM_2 - 2)) w_next = DRAIN;
         DRAIN:   if (w_out_hs && w_last_row) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_klen  <= '0;
         r_beat  <= '0;
         r_shift <= '0;
         r_fc    <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_out_hs && w_last_row;
         r_fc   <= r_state == FLUSH ? r_fc + FW'(1) : '0;
         if (w_start) begin
            r_klen  <= bus.k_len;
            r_shift <= bus.q_shift;
            r_beat  <= '0;
            r_idx   <= '0;
         end else begin
            if (w_beat) r_beat <= r_beat + K_WIDTH'(1);
            if (w_out_hs) r_idx <= r_idx + IW'(1);
         end
      end
   // lane i of A and lane j of B get one extra register each so both skews start from a common stage
   for (genvar i = 0; i < DIM_1; i++) begin : g_askew
      logic [TW-1:0] r_sk [i+1];
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) for (int d = 0; d <= i; d++) r_sk[d] <= '0;
         else begin
            r_sk[0] <= {w_beat, bus.i_2[i*DATA_WIDTH +: DATA_WIDTH]};
            for (int d = 1; d <= i; d++) r_sk[d] <= r_sk[d-1];
         end
      assign w_a_col[i] = r_sk[i];
   end
   for (genvar j = 0; j < DIM_2; j++) begin : g_bskew
      logic [TW-1:0] r_sk [j+1];
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) for (int d = 0; d <= j; d++) r_sk[d] <= '0;
         else begin
            r_sk[0] <= {w_beat, bus.i_1[j*DATA_WIDTH +: DATA_WIDTH]};
            for (int d = 1; d <= j; d++) r_sk[d] <= r_sk[d-1];
         end
      assign w_b_row[j] = r_sk[j];
   end
   for (genvar i = 0; i < DIM_1; i++) begin : g_row
      for (genvar j = 0; j < DIM_2; j++) begin : g_pe
         logic [TW-1:0] w_a, w_b, r_a, r_b;
         logic signed [2*DATA_WIDTH-1:0] w_prod;
         logic signed [ACC_WIDTH-1:0]    r_acc;
         if (j == 0) begin : g_al
            assign w_a = w_a_col[i];
         end else begin : g_ar
            assign w_a = w_ah[i][j-1];
         end
         if (i == 0) begin : g_bt
            assign w_b = w_b_row[j];
         end else begin : g_bd
            assign w_b = w_bv[i-1][j];
         end
         assign w_prod = $signed(w_a[DATA_WIDTH-1:0]) * $signed(w_b[DATA_WIDTH-1:0]);
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               r_a   <= '0;
               r_b   <= '0;
               r_acc <= '0;
            end else begin
               r_a <= w_a;
               r_b <= w_b;
               if (w_start) r_acc <= '0;
               else if (w_a[DATA_WIDTH] && w_b[DATA_WIDTH]) r_acc <= r_acc + ACC_WIDTH'(w_prod);
            end
         assign w_ah[i][j]  = r_a;
         assign w_bv[i][j]  = r_b;
         assign w_acc[i][j] = r_acc;
      end
   end
`ifdef SYSTOLIC_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] QMAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] QMIN = ~QMAX;
`endif
   always_comb begin
      logic signed [ACC_WIDTH-1:0] s;
      w_row = '0;
      for (int j = 0; j < DIM_2; j++) begin
         s = w_acc[r_idx][j] >>> r_shift;
`ifdef SYSTOLIC_SAT_EN
         w_row[j*DATA_WIDTH +: DATA_WIDTH] = s > QMAX ? QMAX[DATA_WIDTH-1:0] : s < QMIN ? QMIN[DATA_WIDTH-1:0] : s[DATA_WIDTH-1:0];
`else
         w_row[j*DATA_WIDTH +: DATA_WIDTH] = s[DATA_WIDTH-1:0];
`endif
      end
   end
   assign bus.in_ready  = r_state == LOAD;
   assign bus.out_valid = w_drain;
   assign bus.out_row   = w_drain ? w_row : '0;
   assign bus.out_idx   = r_idx;
   assign bus.busy      = r_state != IDLE;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_systolic_os_gemm.sv
// tb_systolic_os_gemm: randomized and directed jobs against a matrix-multiply reference with a row scoreboard
module tb_systolic_os_gemm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   systolic_os_gemm_if bif ();
   systolic_os_gemm dut (.clk(clk), .rst_n(rst_n), .bus(bif));
   typedef struct {int idx; logic [63:0] row;} exp_t;
   exp_t exp_q[$];
   int a_m[4][16];
   int b_m[16][4];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction
   function automatic int rnd16();
      logic [15:0] t;
      t = 16'($urandom);
      return int'($signed(t));
   endfunction
   function automatic logic [15:0] quant(longint s);
`ifdef SYSTOLIC_SAT_EN
      if (s > 32767) return 16'h7fff;
      if (s < -32768) return 16'h8000;
`endif
      return s[15:0];
   endfunction
   function automatic void push_expected(int k, int sh);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.idx = i;
         e.row = '0;
         for (int j = 0; j < 4; j++) begin
            longint s = 0;
            for (int kk = 0; kk < k; kk++) s += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
            s = (s <<< 24) >>> 24;
            s = s >>> sh;
            e.row[j*16 +: 16] = quant(s);
         end
         exp_q.push_back(e);
      end
   endfunction
   always @(negedge clk) begin
      if (rst_n && bif.out_valid && bif.out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_row", 64'(bif.out_idx), 64'hdead);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_idx", 64'(bif.out_idx), 64'(e.idx));
            chk("out_row", bif.out_row, e.row);
         end
      end
      if (rst_n && bif.done) done_cnt++;
   end
   task automatic check_outputs_zero(string tag);
      @(negedge clk);
      chk({tag, "_busy"}, 64'(bif.busy), 0);
      chk({tag, "_done"}, 64'(bif.done), 0);
      chk({tag, "_in_ready"}, 64'(bif.in_ready), 0);
      chk({tag, "_out_valid"}, 64'(bif.out_valid), 0);
      chk({tag, "_out_row"}, bif.out_row, 0);
      chk({tag, "_out_idx"}, 64'(bif.out_idx), 0);
   endtask
   task automatic run_job(input int k, input int sh, input int vm, input int bp);
      int beat, cyc, n0;
      logic acc;
      logic [63:0] held;
      push_expected(k, sh);
      n0 = done_cnt;
      @(posedge clk); #1;
      bif.start = 1'b1;
      bif.k_len = 10'(k);
      bif.q_shift = 6'(sh);
      bif.out_ready = bp == 0;
      @(posedge clk); #1;
      bif.start = 1'b0;
      beat = 0;
      cyc = 0;
      while (beat < k && cyc < 400) begin
         bif.in_valid = vm == 0 ? 1'b1 : vm == 1 ? ~cyc[0] : 1'($urandom_range(0, 1));
         for (int i = 0; i < 4; i++) bif.i_2[i*16 +: 16] = 16'(a_m[i][beat]);
         for (int j = 0; j < 4; j++) bif.i_1[j*16 +: 16] = 16'(b_m[beat][j]);
         @(negedge clk);
         acc = bif.in_valid && bif.in_ready;
         @(posedge clk); #1;
         if (acc) beat++;
         cyc++;
      end
      bif.in_valid = 1'b0;
      chk("beats_accepted", 64'(beat), 64'(k));
      @(negedge clk);
      chk("in_ready_after_load", 64'(bif.in_ready), 0);
      if (bp == 1) begin
         cyc = 0;
         while (!bif.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         held = bif.out_row;
         for (int s = 0; s < 5; s++) begin
            chk("stall_out_valid", 64'(bif.out_valid), 1);
            chk("stall_out_idx", 64'(bif.out_idx), 0);
            chk("stall_out_row", bif.out_row, held);
            @(negedge clk);
         end
      end
      @(posedge clk); #1;
      cyc = 0;
      while (done_cnt == n0 && cyc < 400) begin
         bif.out_ready = bp == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      bif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("done_pulses", 64'(done_cnt - n0), 1);
      chk("rows_left", 64'(exp_q.size()), 0);
      chk("busy_after_job", 64'(bif.busy), 0);
   endtask
   task automatic fill(input int av, input int bv);
      for (int i = 0; i < 4; i++) for (int k = 0; k < 16; k++) a_m[i][k] = av;
      for (int k = 0; k < 16; k++) for (int j = 0; j < 4; j++) b_m[k][j] = bv;
   endtask
   task automatic identity_job();
      for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) a_m[i][k] = int'(i == k);
      for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) b_m[k][j] = k * 4 + j + 1;
      run_job(4, 0, 0, 0);
   endtask
   initial begin
      int n0;
      bif.start = 1'b0;
      bif.k_len = '0;
      bif.q_shift = '0;
      bif.in_valid = 1'b0;
      bif.i_1 = '0;
      bif.i_2 = '0;
      bif.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      identity_job();
      fill(1, 1);
      run_job(3, 0, 1, 0);
      for (int i = 0; i < 4; i++) for (int k = 0; k < 4; k++) a_m[i][k] = rnd16();
      for (int k = 0; k < 4; k++) for (int j = 0; j < 4; j++) b_m[k][j] = rnd16();
      run_job(4, 12, 0, 1);
      fill(300, 300);
      run_job(1, 4, 0, 0);
      fill(-2, 3);
      run_job(1, 0, 0, 0);
      fill(32767, 32767);
      run_job(2, 0, 0, 0);
      run_job(0, 0, 0, 0);
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 4; i++) for (int k = 0; k < 16; k++) a_m[i][k] = rnd16();
         for (int k = 0; k < 16; k++) for (int j = 0; j < 4; j++) b_m[k][j] = rnd16();
         run_job($urandom_range(1, 12), $urandom_range(0, 24), $urandom_range(0, 2), $urandom_range(0, 2));
      end
      n0 = done_cnt;
      fill(5, 7);
      @(posedge clk); #1;
      bif.start = 1'b1;
      bif.k_len = 10'd8;
      @(posedge clk); #1;
      bif.start = 1'b0;
      bif.in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      bif.in_valid = 1'b0;
      check_outputs_zero("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - n0), 0);
      chk("abort_idle", 64'(bif.busy), 0);
      identity_job();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
